write_back: RTL and testbench
=============================

Name: write_back

Overview:
- Write-back stage of the 5-stage 16-bit pipeline.
- Selects the result to retire from the ALU result or the memory load data, based on the instruction opcode.
- Registers an updated copy of the 8-entry architectural register file: the destination register gets the result, all others pass through unchanged.
- Outputs feed the register file / decode stage on the next cycle.

Parameters:
- DATA_W, 16, width of data and each register.
- SEL_W, 4, width of opcode and destination-register select.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instruction  in  4  opcode of the instruction in WB.
- alu_output  in  16  ALU result from the EX/MEM pipeline.
- data_from_mem  in  16  load data from the MEM stage.
- reg_nos  in  4  destination register index (0..7 select reg1..reg8).
- reg1_in .. reg8_in  in  16 each  current register-file contents.
- reg1_out .. reg8_out  out  16 each  registered, updated register-file contents.

Behaviour:
- Reset: rst_n low forces reg1_out..reg8_out to 16'h0000 immediately, without waiting for clk. They stay 0 while rst_n is low. The first update occurs on the first rising clk after rst_n deasserts.
- Opcode classes for instruction:
  - 4'h0–4'h2 and 4'h5–4'h9: ALU ops. Write-back data = alu_output, write enabled.
  - 4'h3: LOAD. Write-back data = data_from_mem, write enabled.
  - 4'h4: STORE. No write.
  - 4'hA–4'hE: branch/jump. No write.
  - 4'hF: NOP. No write.
- Destination decode: reg_nos 0..7 maps one-hot to reg1..reg8. reg_nos 8..15 is out of range, so no register is written, even for a writing opcode.
- Each rising clk (rst_n high), for k = 1..8:
  - regk_out <= wb_data if write enabled and reg_nos selects k;
  - otherwise regk_out <= regk_in.
- Latency: one clock from inputs to outputs. Exactly one register is written per cycle at most. Non-selected outputs always track their inputs with one-cycle delay.
- Width: data passes through unmodified; no sign or zero extension, no arithmetic.
- The written value overrides regk_in for the selected register in that cycle.
- Inputs are sampled only at the clock edge; output changes between edges come only from reset.
- Reset asserted mid-operation: outputs clear asynchronously. Any write in flight is discarded.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - DATA_W = 16 and NUM_REGS = 8.
  - Opcode localparams: OP_ADD .. OP_ALU*, OP_LOAD = 4'h3, OP_STORE = 4'h4, OP_BR*, OP_NOP = 4'hF.
  - Function is_writeback(opcode).
- One combinational sub-module, wb_select, is natural:
  - Inputs: instruction, alu_output, data_from_mem, reg_nos.
  - Outputs: wb_data[15:0] and wr_en_onehot[7:0].
- The top level holds the eight 16-bit output registers with async clear.

Test Plan:
- Reset: drive rst_n=0 with random inputs -> all outputs 0 immediately. After rst_n=1 and one edge, outputs equal the inputs.
- ALU write: instruction=4'h0, alu_output=16'h000D, reg1_in=16'h0003, reg_nos=0, one clk -> reg1_out=16'h000D; reg2..8_out equal their inputs (0).
- Load write: then instruction=4'h3, data_from_mem=16'h000F, alu_output=0, reg_nos=0, one clk -> reg1_out=16'h000F, others unchanged.
- Non-writing ops:
  - instruction=4'h4 (STORE), alu_output=16'hBEEF, reg_nos=2 -> reg3_out=reg3_in.
  - Repeat with 4'hF (NOP) and 4'hA (branch): no register altered.
- Destination sweep: reg_nos 0..7 with alu_output=16'h1000+k, instruction=4'h1 -> only reg(k+1)_out takes the value each cycle.
- Out-of-range select: reg_nos=4'h9, instruction=4'h0, alu_output=16'hFFFF -> all outputs equal inputs.
- Async reset mid-stream: assert rst_n low between edges during the load sequence -> outputs clear without a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Opcode map, register-file geometry and opcode classification.
package pipeline_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 4;
  localparam int NUM_REGS = 8;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_BNE   = 4'hB;
  localparam logic [3:0] OP_BLT   = 4'hC;
  localparam logic [3:0] OP_BGE   = 4'hD;
  localparam logic [3:0] OP_JMP   = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  // Stores, branches/jumps and NOP retire nothing.
  function automatic logic is_writeback(
    input logic [3:0] opcode
  );
    logic wr;
    wr = 1'b1;
    unique case (1'b1)
      (opcode == OP_STORE): wr = 1'b0;
      (opcode >= OP_BEQ):   wr = 1'b0;
      default:              wr = 1'b1;
    endcase
    return wr;
  endfunction

  function automatic logic is_load(
    input logic [3:0] opcode
  );
    return opcode == OP_LOAD;
  endfunction

endpackage

// File: rtl/wb_select.sv
// Write-back result mux and destination decode.
// Purely combinational; the caller registers the outcome.
module wb_select
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic [SEL_W-1:0]  instruction,
  input  logic [DATA_W-1:0] alu_output,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [SEL_W-1:0]  reg_nos,
  output logic [DATA_W-1:0] wb_data,
  output logic [7:0]        wr_en_onehot
);

  logic wr_en;
  logic in_range;

  assign wr_en    = is_writeback(instruction);
  assign in_range = (reg_nos < SEL_W'(NUM_REGS));

  // Loads retire memory data, everything else the ALU result.
  always_comb begin
    wb_data = alu_output;
    unique case (1'b1)
      is_load(instruction): wb_data = data_from_mem;
      default:              wb_data = alu_output;
    endcase
  end

  // One-hot destination; selects 8..15 write nothing.
  always_comb begin
    wr_en_onehot = '0;
    if (wr_en && in_range)
      wr_en_onehot[reg_nos[2:0]] = 1'b1;
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: registers the updated register file.
// The selected register takes the result, others pass through.
module write_back
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  instruction,
  input  logic [DATA_W-1:0] alu_output,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [SEL_W-1:0]  reg_nos,
  input  logic [DATA_W-1:0] reg1_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [DATA_W-1:0] reg3_in,
  input  logic [DATA_W-1:0] reg4_in,
  input  logic [DATA_W-1:0] reg5_in,
  input  logic [DATA_W-1:0] reg6_in,
  input  logic [DATA_W-1:0] reg7_in,
  input  logic [DATA_W-1:0] reg8_in,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic [DATA_W-1:0] reg3_out,
  output logic [DATA_W-1:0] reg4_out,
  output logic [DATA_W-1:0] reg5_out,
  output logic [DATA_W-1:0] reg6_out,
  output logic [DATA_W-1:0] reg7_out,
  output logic [DATA_W-1:0] reg8_out
);

  logic [DATA_W-1:0] wb_data;
  logic [7:0]        wr_en_onehot;
  logic [DATA_W-1:0] reg_in  [NUM_REGS];
  logic [DATA_W-1:0] reg_q   [NUM_REGS];

  wb_select #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .instruction   (instruction),
    .alu_output    (alu_output),
    .data_from_mem (data_from_mem),
    .reg_nos       (reg_nos),
    .wb_data       (wb_data),
    .wr_en_onehot  (wr_en_onehot)
  );

  assign reg_in[0] = reg1_in;
  assign reg_in[1] = reg2_in;
  assign reg_in[2] = reg3_in;
  assign reg_in[3] = reg4_in;
  assign reg_in[4] = reg5_in;
  assign reg_in[5] = reg6_in;
  assign reg_in[6] = reg7_in;
  assign reg_in[7] = reg8_in;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    // Async clear; else take result if selected, else pass.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        reg_q[k] <= '0;
      else if (wr_en_onehot[k])
        reg_q[k] <= wb_data;
      else
        reg_q[k] <= reg_in[k];
    end
  end

  assign reg1_out = reg_q[0];
  assign reg2_out = reg_q[1];
  assign reg3_out = reg_q[2];
  assign reg4_out = reg_q[3];
  assign reg5_out = reg_q[4];
  assign reg6_out = reg_q[5];
  assign reg7_out = reg_q[6];
  assign reg8_out = reg_q[7];

endmodule

// File: tb/tb_write_back.sv
// Directed bench for the write-back stage.
// Hand-computed vectors; every check goes through chk.
module tb_write_back;

  logic        clk;
  logic        rst_n;
  logic [3:0]  instruction;
  logic [15:0] alu_output;
  logic [15:0] data_from_mem;
  logic [3:0]  reg_nos;
  logic [15:0] rin  [8];
  logic [15:0] rout [8];
  logic [15:0] exp_r [8];

  int n_chk;
  int n_pass;

  write_back dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .alu_output    (alu_output),
    .data_from_mem (data_from_mem),
    .reg_nos       (reg_nos),
    .reg1_in       (rin[0]),
    .reg2_in       (rin[1]),
    .reg3_in       (rin[2]),
    .reg4_in       (rin[3]),
    .reg5_in       (rin[4]),
    .reg6_in       (rin[5]),
    .reg7_in       (rin[6]),
    .reg8_in       (rin[7]),
    .reg1_out      (rout[0]),
    .reg2_out      (rout[1]),
    .reg3_out      (rout[2]),
    .reg4_out      (rout[3]),
    .reg5_out      (rout[4]),
    .reg6_out      (rout[5]),
    .reg7_out      (rout[6]),
    .reg8_out      (rout[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] want
  );
    n_chk++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s r%0d", tag, i + 1), rout[i], exp_r[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [3:0]  op,
    input logic [15:0] alu,
    input logic [15:0] mem,
    input logic [3:0]  sel
  );
    @(negedge clk);
    instruction   = op;
    alu_output    = alu;
    data_from_mem = mem;
    reg_nos       = sel;
  endtask

  // Writing opcodes: bit n set means opcode n writes.
  localparam logic [15:0] WR_TAB = 16'h03EF;

  logic [15:0] wr_tab;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    wr_tab = WR_TAB;
    rst_n  = 1'b1;
    instruction   = 4'h0;
    alu_output    = 16'h5A5A;
    data_from_mem = 16'hA5A5;
    reg_nos       = 4'h1;
    for (int i = 0; i < 8; i++)
      rin[i] = 16'($urandom);

    // Async reset with no edge between assert and check.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    chk_all("rst_async");
    step();
    chk_all("rst_hold");

    // Release; NOP passes inputs straight through.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      rin[i] = 16'h0100 * 16'(i + 1) + 16'h0011;
    drive(4'hF, 16'hDEAD, 16'hBEEF, 4'h0);
    step();
    for (int i = 0; i < 8; i++) exp_r[i] = rin[i];
    chk_all("rst_release");

    // ALU write to reg1.
    @(negedge clk);
    for (int i = 0; i < 8; i++) rin[i] = 16'h0000;
    rin[0] = 16'h0003;
    drive(4'h0, 16'h000D, 16'h0000, 4'h0);
    step();
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    exp_r[0] = 16'h000D;
    chk_all("alu_wr");

    // Load write to reg1.
    drive(4'h3, 16'h0000, 16'h000F, 4'h0);
    step();
    exp_r[0] = 16'h000F;
    chk_all("load_wr");

    // Store, NOP, branch: nothing changes.
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      rin[i] = 16'h2000 + 16'(i);
    for (int i = 0; i < 8; i++) exp_r[i] = rin[i];
    drive(4'h4, 16'hBEEF, 16'h1234, 4'h2);
    step();
    chk_all("store");
    drive(4'hF, 16'hBEEF, 16'h1234, 4'h2);
    step();
    chk_all("nop");
    drive(4'hA, 16'hBEEF, 16'h1234, 4'h2);
    step();
    chk_all("branch");

    // Destination sweep.
    for (int k = 0; k < 8; k++) begin
      drive(4'h1, 16'h1000 + 16'(k), 16'h7777, 4'(k));
      step();
      for (int i = 0; i < 8; i++) exp_r[i] = rin[i];
      exp_r[k] = 16'h1000 + 16'(k);
      chk_all($sformatf("sweep%0d", k));
    end

    // Out-of-range selects never write.
    drive(4'h0, 16'hFFFF, 16'hFFFF, 4'h9);
    step();
    for (int i = 0; i < 8; i++) exp_r[i] = rin[i];
    chk_all("oor9");
    drive(4'h3, 16'hFFFF, 16'hFFFF, 4'h8);
    step();
    chk_all("oor8");

    // Opcode sweep into reg5: write flag from WR_TAB.
    for (int op = 0; op < 16; op++) begin
      drive(4'(op), 16'hA000 + 16'(op), 16'hC000 + 16'(op), 4'h4);
      step();
      if (wr_tab[op])
        chk($sformatf("op%0h", op), rout[4],
            (op == 3) ? 16'hC003 : 16'hA000 + 16'(op));
      else
        chk($sformatf("op%0h", op), rout[4], 16'h2004);
      chk($sformatf("op%0h r4", op), rout[3], 16'h2003);
    end

    // Reset mid-load: clears between edges, write discarded.
    drive(4'h3, 16'h0000, 16'h4321, 4'h1);
    step();
    chk("mid_pre", rout[1], 16'h4321);
    drive(4'h3, 16'h0000, 16'h9876, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    chk_all("mid_rst");
    step();
    chk_all("mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) exp_r[i] = rin[i];
    exp_r[1] = 16'h9876;
    chk_all("mid_release");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
